// File: rtl/rgb_pwm_sequencer.sv
// RGB colour sequencer: prescaled tick ramps a PWM duty through RED -> GREEN -> BLUE.
// Optional column chase pointer is enabled by defining CHASE_EN.
module rgb_pwm_sequencer #(
   parameter int CH            = 25,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          mode,
   output logic [CH-1:0] r,
   output logic [CH-1:0] g,
   output logic [CH-1:0] b,
   output logic [1:0]    state,
   output logic [2:0]    leds,
   output logic          seq_wrap
);

   typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2, ILLEGAL = 2'd3} colour_t;

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic [PRESCALE_BITS-1:0] pre_cnt;
   logic                     pre_msb_q;
   logic                     tick;
   logic [PWM_BITS-1:0]      pwm_cnt;
   logic                     active;

   logic [1:0]               state_q, state_d;
   logic [PWM_BITS-1:0]      duty_q, duty_d;
   logic                     dir_down_q, dir_down_d;
   logic                     advance;
   logic                     wrap_d;
   logic [CH-1:0]            col_mask;
   logic [CH-1:0]            r_d, g_d, b_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; combinational blocks use blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt   <= '0;
         pre_msb_q <= 1'b0;
      end else if (en) begin
         pre_cnt   <= pre_cnt + 1'b1;
         pre_msb_q <= pre_cnt[PRESCALE_BITS-1];
      end
   end

   // Gated by en so a tick cannot stay asserted while the prescaler is frozen.
   assign tick = en & pre_cnt[PRESCALE_BITS-1] & ~pre_msb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm_cnt <= '0;
      else     pwm_cnt <= pwm_cnt + 1'b1;
   end

   assign active = (pwm_cnt < duty_q);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RED;
         duty_q     <= '0;
         dir_down_q <= 1'b0;
         seq_wrap   <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         dir_down_q <= dir_down_d;
         seq_wrap   <= wrap_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      duty_d     = duty_q;
      dir_down_d = dir_down_q;
      advance    = 1'b0;
      if (tick) begin
         if (state_q == ILLEGAL) begin
            state_d = RED;
         end else if (!dir_down_q) begin
            if (duty_q != MAX) begin
               duty_d = duty_q + 1'b1;
            end else if (!mode) begin
               duty_d  = '0;
               advance = 1'b1;
            end else begin
               dir_down_d = 1'b1;
               duty_d     = MAX - 1'b1;
            end
         end else begin
            if (duty_q != '0) begin
               duty_d = duty_q - 1'b1;
            end else begin
               dir_down_d = 1'b0;
               advance    = 1'b1;
            end
         end
         if (advance) begin
            case (state_q)
               RED:     state_d = GREEN;
               GREEN:   state_d = BLUE;
               default: state_d = RED;
            endcase
         end
      end
      wrap_d = advance && (state_q == BLUE);
   end

`ifdef CHASE_EN
   localparam int COL_W = (CH > 1) ? $clog2(CH) : 1;
   logic [COL_W-1:0] col_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          col_q <= '0;
      else if (advance) col_q <= (col_q == COL_W'(CH - 1)) ? '0 : col_q + 1'b1;
   end

   assign col_mask = CH'(1) << col_q;
`else
   assign col_mask = '1;
`endif

   // Output decode
   always_comb begin
      leds = 3'b000;
      r_d  = '0;
      g_d  = '0;
      b_d  = '0;
      case (state_q)
         RED:     leds = 3'b001;
         GREEN:   leds = 3'b010;
         BLUE:    leds = 3'b100;
         default: leds = 3'b000;
      endcase
      if (active) begin
         case (state_q)
            RED:     r_d = col_mask;
            GREEN:   g_d = col_mask;
            BLUE:    b_d = col_mask;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r <= '0;
         g <= '0;
         b <= '0;
      end else begin
         r <= r_d;
         g <= g_d;
         b <= b_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with CH=4, PWM_BITS=2, PRESCALE_BITS=2 (MAX=3, tick every 4 clocks).
// Column-chase expectations follow CHASE_EN.
module tb_rgb_pwm_sequencer;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic [3:0] r;
   logic [3:0] g;
   logic [3:0] b;
   logic [1:0] state;
   logic [2:0] leds;
   logic       seq_wrap;

   int vectors = 0;
   int errors  = 0;

   rgb_pwm_sequencer #(
      .CH(4),
      .PWM_BITS(2),
      .PRESCALE_BITS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .r(r),
      .g(g),
      .b(b),
      .state(state),
      .leds(leds),
      .seq_wrap(seq_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a tick at a falling edge, then one more falling edge so the update is visible.
   task automatic do_tick();
      int n = 0;
      while (dut.tick !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (n >= 16) begin
         vectors++;
         errors++;
         $display("FAIL tick_timeout: no tick within 16 clocks");
      end
      @(negedge clk);
   endtask

   initial begin
      int         ones;
      int         zeros;
      int         gb_hits;
      int         nticks;
      int         tri_exp [6];
      logic [11:0] acc;
      logic [3:0]  mask;
      logic [11:0] exp_acc;

      tri_exp = '{1, 2, 3, 2, 1, 0};
      rst  = 1'b1;
      en   = 1'b0;
      mode = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state",    32'(state),       0);
      check("rst_leds",     32'(leds),        1);
      check("rst_rgb",      32'({b, g, r}),   0);
      check("rst_seq_wrap", 32'(seq_wrap),    0);

      // Run part-way into the sequence, then reset asynchronously between edges
      rst = 1'b0;
      en  = 1'b1;
      repeat (30) @(negedge clk);
      check("midrun_not_red", 32'(state != 2'd0), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_state", 32'(state),      0);
      check("async_rst_leds",  32'(leds),       1);
      check("async_rst_rgb",   32'({b, g, r}),  0);
      check("async_rst_wrap",  32'(seq_wrap),   0);
      check("async_rst_duty",  32'(dut.duty_q), 0);
      @(negedge clk);
      rst = 1'b0;

      // Tick period: one clock wide, every 4 clocks
      do_tick();
      check("saw_duty_t1",  32'(dut.duty_q), 1);
      check("tick_width",   32'(dut.tick),   0);
      @(negedge clk);
      check("tick_gap_2",   32'(dut.tick),   0);
      @(negedge clk);
      check("tick_gap_3",   32'(dut.tick),   0);
      @(negedge clk);
      check("tick_period",  32'(dut.tick),   1);

      // Sawtooth
      do_tick();
      check("saw_duty_t2",  32'(dut.duty_q), 2);
      do_tick();
      check("saw_duty_t3",  32'(dut.duty_q), 3);
      check("saw_state_t3", 32'(state),      0);
      do_tick();
      check("saw_duty_t4",  32'(dut.duty_q), 0);
      check("saw_state_t4", 32'(state),      1);
      check("saw_leds_t4",  32'(leds),       2);
      repeat (7) do_tick();
      check("saw_state_t11", 32'(state),      2);
      check("saw_duty_t11",  32'(dut.duty_q), 3);
      check("saw_nowrap_t11", 32'(seq_wrap),  0);
      do_tick();
      check("saw_wrap_t12",  32'(seq_wrap),   1);
      check("saw_state_t12", 32'(state),      0);
      check("saw_leds_t12",  32'(leds),       1);
      @(negedge clk);
      check("saw_wrap_1clk", 32'(seq_wrap),   0);

      // Triangle
      mode = 1'b1;
      for (int i = 0; i < 6; i++) begin
         do_tick();
         check("tri_duty",  32'(dut.duty_q), 32'(tri_exp[i]));
         check("tri_state", 32'(state),      0);
      end
      do_tick();
      check("tri_state_t7", 32'(state),      1);
      check("tri_duty_t7",  32'(dut.duty_q), 0);
      repeat (13) do_tick();
      check("tri_state_t20",  32'(state),    2);
      check("tri_nowrap_t20", 32'(seq_wrap), 0);
      do_tick();
      check("tri_wrap_t21",  32'(seq_wrap),  1);
      check("tri_state_t21", 32'(state),     0);

      // PWM at duty 2 in RED with the ramp frozen
      mode = 1'b0;
      do_tick();
      do_tick();
      check("pwm_duty_setup", 32'(dut.duty_q), 2);
      en = 1'b0;
      @(negedge clk);
      ones    = 0;
      zeros   = 0;
      gb_hits = 0;
      for (int i = 0; i < 8; i++) begin
         if (r === 4'hF) ones++;
         if (r === 4'h0) zeros++;
         if ((g | b) !== 4'h0) gb_hits++;
         @(negedge clk);
      end
      check("pwm_on_count",  32'(ones),    4);
      check("pwm_off_count", 32'(zeros),   4);
      check("pwm_gb_zero",   32'(gb_hits), 0);

      nticks = 0;
      repeat (20) begin
         @(negedge clk);
         if (dut.tick === 1'b1) nticks++;
      end
      check("pause_no_tick", 32'(nticks),     0);
      check("pause_duty",    32'(dut.duty_q), 2);
      check("pause_state",   32'(state),      0);

      // Illegal state recovers to RED on the next tick
      force dut.state_q = 2'd3;
      #1;
      check("illegal_leds",  32'(leds),  0);
      check("illegal_state", 32'(state), 3);
      @(negedge clk);
      @(negedge clk);
      check("illegal_rgb",   32'({b, g, r}), 0);
      release dut.state_q;
      @(negedge clk);
      check("illegal_hold",  32'(state), 3);
      en = 1'b1;
      do_tick();
      check("illegal_to_red",  32'(state), 0);
      check("illegal_leds_ok", 32'(leds),  1);

      // Switching to sawtooth during a down-ramp finishes the ramp first
      mode = 1'b1;
      do_tick();
      check("msw_duty_up",   32'(dut.duty_q), 3);
      do_tick();
      check("msw_duty_down", 32'(dut.duty_q), 2);
      mode = 1'b0;
      do_tick();
      check("msw_duty_1",    32'(dut.duty_q), 1);
      do_tick();
      check("msw_duty_0",    32'(dut.duty_q), 0);
      check("msw_state_hold", 32'(state),     0);
      do_tick();
      check("msw_advance",   32'(state),      1);

      // Column pattern across six colour advances
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      mode = 1'b0;
      en   = 1'b1;
      for (int c = 0; c < 6; c++) begin
         repeat (3) do_tick();
         acc = '0;
         repeat (3) begin
            acc = acc | {b, g, r};
            @(negedge clk);
         end
`ifdef CHASE_EN
         mask = 4'b0001 << (c % 4);
`else
         mask = 4'hF;
`endif
         exp_acc = 12'(mask) << (4 * (c % 3));
         check("column_pattern", 32'(acc), 32'(exp_acc));
         do_tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
